// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - op-in / result-out handshake bundle for alu_exec_stage
//
// Purpose: groups the upstream op channel and the downstream result channel.
// Ports (signals):
//   in_valid/in_ready              op handshake
//   in_a, in_b                     32-bit operands
//   in_a_or_l, in_s_or_u           arithmetic/logic select, signedness
//   in_opcode, in_tag              ALU opcode, opaque destination tag
//   out_valid/out_ready            result handshake
//   out_result, out_tag, out_dz    captured result, its tag, divide-by-zero flag
// Modports: slave = the stage, master = the producer/consumer side.
interface alu_exec_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_a_or_l;
  logic        in_s_or_u;
  logic [2:0]  in_opcode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_dz;

  modport slave (
    input  in_valid, in_a, in_b, in_a_or_l, in_s_or_u, in_opcode, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_dz
  );

  modport master (
    output in_valid, in_a, in_b, in_a_or_l, in_s_or_u, in_opcode, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_dz
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute-stage sequencer in front of the Alu block
//
// Purpose: accepts one ALU op per handshake, registers it onto the Alu inputs,
// holds it for the op's settle time (1 cycle, or MULDIV_CYCLES for mul/div),
// then captures the Alu answer into a result register for writeback.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   bus (slave)     op input channel and result output channel
//   alu_a, alu_b, alu_a_or_l, alu_s_or_u, alu_opcode   registered Alu inputs
//   alu_answer      Alu AnswerOne
//   busy            stage not idle
module alu_exec_stage #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  alu_exec_stage_if.slave    bus,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic               alu_a_or_l,
  output logic               alu_s_or_u,
  output logic [2:0]         alu_opcode,
  input  logic [31:0]        alu_answer,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter holds remaining extra settle cycles; 4 bits covers 1..15.
  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic        alu_a_or_l_q, alu_a_or_l_d;
  logic        alu_s_or_u_q, alu_s_or_u_d;
  logic [2:0]  alu_opcode_q, alu_opcode_d;
  logic [3:0]  tag_q, tag_d;
  logic        dz_q, dz_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [3:0]  out_tag_q, out_tag_d;
  logic        out_dz_q, out_dz_d;
  logic        busy_q, busy_d;

  logic        in_ready;
  logic        accept;
  logic        new_dz;
  logic        new_multi;

  // Ready is purely a function of state and out_ready so upstream never sees
  // a combinational path from its own valid.
  assign in_ready = ~reset & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;

  // Divide by zero short-circuits the settle time: the answer is forced anyway.
  assign new_dz    = ~bus.in_a_or_l & (bus.in_opcode[1:0] == 2'b11) & (bus.in_b == '0);
  assign new_multi = ~bus.in_a_or_l & bus.in_opcode[1] & ~new_dz;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_a_or_l_d = alu_a_or_l_q;
    alu_s_or_u_d = alu_s_or_u_q;
    alu_opcode_d = alu_opcode_q;
    tag_d        = tag_q;
    dz_d         = dz_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_dz_d     = out_dz_q;

    case (state_q)
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          out_valid_d  = 1'b1;
          out_result_d = dz_q ? 32'hFFFF_FFFF : alu_answer;
          out_tag_d    = tag_q;
          out_dz_d     = dz_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: ;
    endcase

    // Acceptance overrides the DONE->IDLE move so there is no bubble.
    if (accept) begin
      alu_a_d      = bus.in_a;
      alu_b_d      = bus.in_b;
      alu_a_or_l_d = bus.in_a_or_l;
      alu_s_or_u_d = bus.in_s_or_u;
      alu_opcode_d = bus.in_opcode;
      tag_d        = bus.in_tag;
      dz_d         = new_dz;
      cnt_d        = new_multi ? MD_LOAD : 4'd0;
      state_d      = EXEC;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_a_or_l_q <= 1'b0;
      alu_s_or_u_q <= 1'b0;
      alu_opcode_q <= 3'd0;
      tag_q        <= 4'd0;
      dz_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= 4'd0;
      out_dz_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_a_or_l_q <= alu_a_or_l_d;
      alu_s_or_u_q <= alu_s_or_u_d;
      alu_opcode_q <= alu_opcode_d;
      tag_q        <= tag_d;
      dz_q         <= dz_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_dz_q     <= out_dz_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_dz     = out_dz_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_a_or_l     = alu_a_or_l_q;
  assign alu_s_or_u     = alu_s_or_u_q;
  assign alu_opcode     = alu_opcode_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage
module tb_alu_exec_stage;
  localparam int MD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b, alu_answer;
  logic        alu_a_or_l, alu_s_or_u, busy;
  logic [2:0]  alu_opcode;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ecnt    = 0;

  alu_exec_stage_if bus ();

  alu_exec_stage #(.MULDIV_CYCLES(MD)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_a_or_l (alu_a_or_l),
    .alu_s_or_u (alu_s_or_u),
    .alu_opcode (alu_opcode),
    .alu_answer (alu_answer),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural Alu: divide by zero returns junk that the stage must ignore.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic aol, input logic sou, input logic [2:0] opc);
    logic [31:0] r;
    if (aol) begin
      case (opc)
        3'd0: r = a & b;
        3'd1: r = a | b;
        3'd2: r = a ^ b;
        3'd3: r = ~(a | b);
        3'd4: r = ~(a & b);
        3'd5: r = ~(a ^ b);
        3'd6: r = a;
        default: r = ~a;
      endcase
    end else begin
      case (opc[1:0])
        2'd0: r = a + b;
        2'd1: r = a - b;
        2'd2: r = a * b;
        default: begin
          if (b == 32'd0) r = 32'hDEAD_BEEF;
          else if (sou) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = $signed(a) / $signed(b);
          end else r = a / b;
        end
      endcase
    end
    return r;
  endfunction

  always_comb alu_answer = alu_fn(alu_a, alu_b, alu_a_or_l, alu_s_or_u, alu_opcode);

  typedef struct {
    logic [31:0] a, b, res;
    logic        aol, sou, dz;
    logic [2:0]  opc;
    logic [3:0]  tag;
    int          acc, lat;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic aol,
                          input logic sou, input logic [2:0] opc, input logic [3:0] tag);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_a_or_l = aol;
    bus.in_s_or_u = sou;
    bus.in_opcode = opc;
    bus.in_tag    = tag;
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic aol, input logic sou, input logic [2:0] opc,
                        input logic [3:0] tag, input logic [31:0] exp_res, input logic exp_dz,
                        input int exp_lat, input int bp, input bit do_release);
    int e;
    bus.out_ready = (bp == 0);
    drive_op(a, b, aol, sou, opc, tag);
    #1;
    chk({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    e = 0;
    while (!bus.out_valid && e < 40) begin
      chk({nm, " alu_a held"}, alu_a, a);
      chk({nm, " alu_b held"}, alu_b, b);
      chk({nm, " alu_ctl held"}, 32'({alu_a_or_l, alu_s_or_u, alu_opcode}), 32'({aol, sou, opc}));
      tick();
      e++;
    end
    chk({nm, " latency"}, 32'(e), 32'(exp_lat));
    chk({nm, " result"}, bus.out_result, exp_res);
    chk({nm, " tag"}, 32'(bus.out_tag), 32'(tag));
    chk({nm, " dz"}, 32'(bus.out_dz), 32'(exp_dz));
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({nm, " bp valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, " bp result"}, bus.out_result, exp_res);
      chk({nm, " bp tag"}, 32'(bus.out_tag), 32'(tag));
      chk({nm, " bp in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({nm, " bp busy"}, 32'(busy), 32'd1);
    end
    if (do_release) begin
      bus.out_ready = 1'b1;
      tick();
      chk({nm, " valid drop"}, 32'(bus.out_valid), 32'd0);
      chk({nm, " idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int   k, got, last;
    bit   hs_in, hs_out, exp_ov;
    exp_t en;

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_a_or_l = 1'b0; bus.in_s_or_u = 1'b0;
    bus.in_opcode = 3'd0; bus.in_tag = 4'd0;
    tick(); tick();
    chk("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_result", bus.out_result, 32'd0);
    chk("rst out_tag_dz", 32'({bus.out_tag, bus.out_dz}), 32'd0);
    chk("rst alu_a", alu_a, 32'd0);
    chk("rst alu_b", alu_b, 32'd0);
    chk("rst alu_ctl", 32'({alu_a_or_l, alu_s_or_u, alu_opcode}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    reset = 1'b0;
    #1;
    chk("post rst in_ready", 32'(bus.in_ready), 32'd1);

    // Directed cases.
    run_op("add", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 3'b000, 4'd3, 32'h8000_0000, 1'b0, 1, 0, 1'b1);
    run_op("mul", 32'd6, 32'hFFFF_FFF9, 1'b0, 1'b1, 3'b010, 4'd7, 32'hFFFF_FFD6, 1'b0, MD, 0, 1'b1);
    run_op("divz", 32'd100, 32'd0, 1'b0, 1'b1, 3'b011, 4'd9, 32'hFFFF_FFFF, 1'b1, 1, 0, 1'b1);
    run_op("div", 32'd100, 32'd7, 1'b0, 1'b0, 3'b011, 4'd2, 32'd14, 1'b0, MD, 0, 1'b1);

    // Backpressure then same-edge acceptance of the next op.
    run_op("bp", 32'd10, 32'd3, 1'b0, 1'b0, 3'b001, 4'd4, 32'd7, 1'b0, 1, 3, 1'b0);
    bus.out_ready = 1'b1;
    drive_op(32'hF0F0_0000, 32'h0FF0_0000, 1'b1, 1'b0, 3'd1, 4'd5);
    #1;
    chk("bp2 in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp2 valid gap", 32'(bus.out_valid), 32'd0);
    chk("bp2 busy", 32'(busy), 32'd1);
    tick();
    chk("bp2 valid", 32'(bus.out_valid), 32'd1);
    chk("bp2 result", bus.out_result, 32'hFFF0_0000);
    chk("bp2 tag", 32'(bus.out_tag), 32'd5);
    tick();
    chk("bp2 drop", 32'(bus.out_valid), 32'd0);

    // Back-to-back logic ops, out_ready tied high.
    k = 0; got = 0; last = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (k < 4) drive_op(32'(k * 16 + 5), 32'h0000_00FF, 1'b1, 1'b0, 3'(k), 4'(k));
      else bus.in_valid = 1'b0;
      #1;
      hs_in = bus.in_valid && bus.in_ready;
      tick();
      if (hs_in) k++;
      if (bus.out_valid) begin
        chk("b2b tag", 32'(bus.out_tag), 32'(got));
        chk("b2b result", bus.out_result,
            alu_fn(32'(got * 16 + 5), 32'h0000_00FF, 1'b1, 1'b0, 3'(got)));
        if (got > 0) chk("b2b spacing", 32'(ecnt - last), 32'd2);
        last = ecnt;
        got++;
      end
    end
    chk("b2b count", 32'(got), 32'd4);
    bus.in_valid = 1'b0;
    tick();

    // Reset during a mul in EXEC drops the op.
    drive_op(32'd6, 32'd9, 1'b0, 1'b0, 3'b010, 4'd11);
    tick();
    bus.in_valid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst2 in_ready low", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst2 out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst2 out_result", bus.out_result, 32'd0);
    chk("rst2 alu_a", alu_a, 32'd0);
    chk("rst2 alu_ctl", 32'({alu_a_or_l, alu_s_or_u, alu_opcode}), 32'd0);
    chk("rst2 busy", 32'(busy), 32'd0);
    chk("rst2 in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst2 no result", 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic against a transaction-level model.
    for (int c = 0; c < 400 || (q.size() > 0 && c < 500); c++) begin
      exp_ov = (q.size() > 0) && (ecnt >= q[0].acc + q[0].lat);
      chk("rnd out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("rnd busy", 32'(busy), 32'(q.size() != 0));
      if (exp_ov) begin
        chk("rnd result", bus.out_result, q[0].res);
        chk("rnd tag", 32'(bus.out_tag), 32'(q[0].tag));
        chk("rnd dz", 32'(bus.out_dz), 32'(q[0].dz));
      end
      if (q.size() > 0) begin
        chk("rnd alu_a", alu_a, q[0].a);
        chk("rnd alu_b", alu_b, q[0].b);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_a      = $urandom;
      bus.in_b      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.in_a_or_l = 1'($urandom_range(0, 1));
      bus.in_s_or_u = 1'($urandom_range(0, 1));
      bus.in_opcode = 3'($urandom);
      bus.in_tag    = 4'($urandom);
      #1;
      chk("rnd in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || (exp_ov && bus.out_ready)));
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = exp_ov && bus.out_ready;
      en.a = bus.in_a; en.b = bus.in_b; en.aol = bus.in_a_or_l; en.sou = bus.in_s_or_u;
      en.opc = bus.in_opcode; en.tag = bus.in_tag;
      en.dz  = !en.aol && (en.opc[1:0] == 2'b11) && (en.b == 32'd0);
      en.res = en.dz ? 32'hFFFF_FFFF : alu_fn(en.a, en.b, en.aol, en.sou, en.opc);
      en.lat = (!en.aol && en.opc[1] && !en.dz) ? MD : 1;
      tick();
      if (hs_out) void'(q.pop_front());
      if (hs_in) begin
        en.acc = ecnt;
        q.push_back(en);
      end
    end
    chk("rnd drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute-stage sequencer that sits directly upstream of the `Alu` block and also captures what it produces. It accepts one ALU operation per valid/ready handshake and registers the operands and control onto the ALU inputs. It holds them stable for the operation's settle time: 1 cycle for add/sub/logic, MULDIV_CYCLES for mul/div. It then captures `AnswerOne` into a result register with its own valid/ready handshake toward writeback.

## Interface
- MULDIV_CYCLES, 4, cycles ALU operands are held for arithmetic mul/div; legal range 1..15
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  upstream op available
- in_ready  out  1  stage can accept an op this cycle
- in_a, in_b  in  32 each  operands
- in_a_or_l  in  1  0 = arithmetic result, 1 = logic result
- in_s_or_u  in  1  1 = signed, 0 = unsigned arithmetic
- in_opcode  in  3  ALU OpCode; arithmetic uses [1:0]: 00 add, 01 sub, 10 mul, 11 div
- in_tag  in  4  opaque destination tag, returned with result
- alu_a, alu_b  out  32 each  registered operands to `Alu` A/B
- alu_a_or_l, alu_s_or_u  out  1 each  registered to `Alu` A_or_L/S_or_U
- alu_opcode  out  3  registered to `Alu` OpCode
- alu_answer  in  32  from `Alu` AnswerOne
- out_valid  out  1  result register holds a result
- out_ready  in  1  downstream accepts result
- out_result  out  32  captured result
- out_tag  out  4  tag of captured result
- out_dz  out  1  result came from divide by zero
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, DONE.
- IDLE: in_ready=1. On in_valid, load alu_* and the tag register, and go to EXEC.
- On entry to EXEC, load the down-counter with MULDIV_CYCLES-1 if the op is multicycle, else with 0.
  - An op is multicycle when a_or_l=0 and opcode[1]=1.
- Divide by zero:
  - Condition: a_or_l=0, opcode[1:0]=11, in_b=0. The counter is loaded with 0 regardless of MULDIV_CYCLES.
  - At capture, out_result=32'hFFFF_FFFF and out_dz=1. alu_answer is ignored.
- EXEC: while count≠0, decrement. When count=0, capture alu_answer, tag and dz into the out_* registers, set out_valid=1, and go to DONE.
- DONE: out_valid=1 and out_* are held stable while out_ready=0.
  - out_ready=1 with in_valid=0: clear out_valid and go to IDLE.
  - out_ready=1 with in_valid=1: in_ready=1. Load the new op (same as IDLE acceptance), clear out_valid and go to EXEC.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready; it never depends on in_valid.
- alu_* outputs change only on an accepted handshake. They stay stable throughout EXEC and DONE.
- The ALU's arithmetic and width rules belong to `Alu`: results are 32 bits, carry/overflow are dropped, and signedness is per in_s_or_u. This stage passes them through unmodified.

## Timing
- Reset value of every output:
  - out_valid=0, out_result=0, out_tag=0, out_dz=0
  - alu_a=alu_b=0, alu_a_or_l=0, alu_s_or_u=0, alu_opcode=0
  - busy=0, state=IDLE
- in_ready is 0 while reset is high. It is 1 in the first cycle after reset deasserts.
- Latency (handshake edge E0 to out_valid=1):
  - Single-cycle op and div-by-zero: out_valid rises after edge E1.
  - Multicycle op: out_valid rises after edge E(MULDIV_CYCLES).
- Throughput: single-cycle ops with out_ready held high complete one op per 2 cycles. There is no bubble between DONE and the next acceptance.
- Reset mid-operation, in EXEC or DONE: the op is dropped without producing an output. All registers take their reset values at that edge.
- A handshake is never lost: an op accepted on an edge always produces exactly one out_valid result unless reset intervenes.

## Test plan
- Add: a_or_l=0, opcode=000, a=0x7FFF_FFFF, b=1, tag=3. Expect out_valid 1 cycle after the handshake, out_result=0x8000_0000, out_tag=3, out_dz=0.
- Multicycle mul with MULDIV_CYCLES=4: opcode=010, s_or_u=1, a=6, b=-7. Expect out_valid exactly 4 cycles after the handshake, out_result=0xFFFF_FFD6, and alu_* stable for all 4 cycles.
- Divide by zero: opcode=011, a=100, b=0, tag=9. Expect out_valid after 1 cycle, out_result=0xFFFF_FFFF, out_dz=1, out_tag=9.
- Backpressure: complete an op with out_ready=0 for 3 cycles. Expect out_* constant, in_ready=0 and busy=1. Raise out_ready with in_valid=1: the next op is accepted on the same edge and out_valid drops for 1 cycle.
- Back-to-back logic ops (a_or_l=1) with out_ready tied to 1: expect one result every 2 cycles, with tags in issue order 0,1,2,3.
- Reset asserted in EXEC of a mul: expect no out_valid. After release, all outputs are 0 and in_ready=1.
